// File: rtl/llac_i2s_tx.sv
// llac_i2s_tx: I2S master transmitter, Philips format, MSB first, one-pair holding buffer
// Ports:
//   clk_100mhz, resetn           - sole clock, asynchronous active-low reset
//   enable                       - run the serializer; low forces the idle state
//   audio_left_in/right_in/valid - parallel stereo pair input
//   audio_ready_out              - holding register empty
//   i2s_bclk/lrclk/sdata         - serial bus to the DAC (lrclk 0 = left)
//   frame_start/underflow        - one-cycle pulses on frame load (underflow when nothing was held)
module llac_i2s_tx #(
    parameter int AUDIO_WIDTH   = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int BCLK_HALF_DIV = 16
) (
    input  logic                   clk_100mhz,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [AUDIO_WIDTH-1:0] audio_left_in,
    input  logic [AUDIO_WIDTH-1:0] audio_right_in,
    input  logic                   audio_valid_in,
    output logic                   audio_ready_out,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic                   frame_start,
    output logic                   underflow
);
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam int DW = BCLK_HALF_DIV > 1 ? $clog2(BCLK_HALF_DIV) : 1;
    localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_HALF_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] L_LAST   = BW'(AUDIO_WIDTH);
    localparam logic [BW-1:0] R_FIRST  = BW'(SLOT_WIDTH + 1);
    localparam logic [BW-1:0] R_LAST   = BW'(SLOT_WIDTH + AUDIO_WIDTH);

    logic [DW-1:0]          r_div_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [AUDIO_WIDTH-1:0] r_hold_l, r_hold_r, r_frm_l, r_frm_r;
    logic [BW-1:0]          w_bit_nxt;
    logic                   w_fall, w_load, w_accept, w_in_l, w_in_r;

    always_comb begin
        w_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
        w_fall    = enable && r_div_cnt == DIV_TC && i2s_bclk;
        w_load    = w_fall && w_bit_nxt == '0;
        w_accept  = audio_valid_in && audio_ready_out;
        w_in_l    = w_bit_nxt != '0 && w_bit_nxt <= L_LAST;
        w_in_r    = w_bit_nxt >= R_FIRST && w_bit_nxt <= R_LAST;
    end

    // Frame registers are shifted MSB-out so each slot bit is just the top bit.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt       <= '0;
            r_bit_cnt       <= BIT_LAST;
            r_hold_l        <= '0;
            r_hold_r        <= '0;
            r_frm_l         <= '0;
            r_frm_r         <= '0;
            audio_ready_out <= 1'b1;
            i2s_bclk        <= 1'b0;
            i2s_lrclk       <= 1'b1;
            i2s_sdata       <= 1'b0;
            frame_start     <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            // An accept coinciding with an empty-buffer load lands in the buffer, not the frame.
            if (w_accept) begin
                r_hold_l        <= audio_left_in;
                r_hold_r        <= audio_right_in;
                audio_ready_out <= 1'b0;
            end else if (w_load) begin
                audio_ready_out <= 1'b1;
            end
            if (!enable) begin
                r_div_cnt <= '0;
                r_bit_cnt <= BIT_LAST;
                i2s_bclk  <= 1'b0;
                i2s_lrclk <= 1'b1;
                i2s_sdata <= 1'b0;
            end else if (r_div_cnt != DIV_TC) begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
                i2s_bclk  <= ~i2s_bclk;
                if (w_fall) begin
                    r_bit_cnt <= w_bit_nxt;
                    i2s_lrclk <= w_bit_nxt >= SLOT;
                    i2s_sdata <= 1'b0;
                    if (w_load) begin
                        r_frm_l     <= audio_ready_out ? '0 : r_hold_l;
                        r_frm_r     <= audio_ready_out ? '0 : r_hold_r;
                        frame_start <= 1'b1;
                        underflow   <= audio_ready_out;
                    end else if (w_in_l) begin
                        i2s_sdata <= r_frm_l[AUDIO_WIDTH-1];
                        r_frm_l   <= r_frm_l << 1;
                    end else if (w_in_r) begin
                        i2s_sdata <= r_frm_r[AUDIO_WIDTH-1];
                        r_frm_r   <= r_frm_r << 1;
                    end
                end
            end
        end
    end
endmodule
